// File: rtl/stupidrv_pkg.sv
// Shared types for the stupidrv memory arbiter.
// State and last-op encodings plus the memory latency constant.
package stupidrv_pkg;

    typedef enum logic {
        IDLE,
        FETCH2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_FETCH,
        OP_DATA
    } last_op_t;

    localparam int MEM_LATENCY = 1;

endpackage

// File: rtl/stupidrv_memarb.sv
// Single-port memory arbiter: data access first, then fetch.
// Tracks the previous memory op to steer read data to the right port.
module stupidrv_memarb
    import stupidrv_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               imem_addr,
    output logic [31:0]               imem_data,
    input  logic                      dmem_valid,
    input  logic [31:0]               dmem_addr,
    input  logic [3:0]                dmem_wstrb,
    input  logic [31:0]               dmem_wdata,
    output logic [31:0]               dmem_rdata,
    output logic                      stall,
    output logic                      mem_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]                mem_wstrb,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    output logic [31:0]               stall_cycles
);

    state_t      state_q, state_d;
    last_op_t    last_op_q, last_op_d;
    logic [31:0] fetch_hold_q;
    logic [31:0] data_hold_q;
    logic [31:0] stall_cnt_q;

    // Address bits outside the word index are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[31:MEM_ADDR_WIDTH+2],
                                imem_addr[1:0],
                                dmem_addr[31:MEM_ADDR_WIDTH+2],
                                dmem_addr[1:0]};

    // Next state and memory-port steering; reset forces a stalled idle port.
    always_comb begin
        state_d   = state_q;
        last_op_d = OP_NONE;
        stall     = 1'b1;
        mem_en    = 1'b0;
        mem_addr  = imem_addr[MEM_ADDR_WIDTH+1:2];
        mem_wstrb = 4'b0000;
        mem_wdata = dmem_wdata;
        if (reset) begin
            unique case (state_q)
                IDLE: begin
                    mem_en = 1'b1;
                    if (dmem_valid) begin
                        stall     = 1'b1;
                        mem_addr  = dmem_addr[MEM_ADDR_WIDTH+1:2];
                        mem_wstrb = dmem_wstrb;
                        last_op_d = OP_DATA;
                        state_d   = FETCH2;
                    end else begin
                        stall     = 1'b0;
                        last_op_d = OP_FETCH;
                    end
                end
                FETCH2: begin
                    mem_en    = 1'b1;
                    stall     = 1'b0;
                    last_op_d = OP_FETCH;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Fresh fetch data passes straight through; otherwise the held word.
    always_comb begin
        imem_data = (last_op_q == OP_FETCH) ? mem_rdata : fetch_hold_q;
    end

    assign dmem_rdata   = data_hold_q;
    assign stall_cycles = stall_cnt_q;

    // State, hold registers and the free-running stall counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_op_q    <= OP_NONE;
            fetch_hold_q <= 32'd0;
            data_hold_q  <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            last_op_q <= last_op_d;
            if (last_op_q == OP_FETCH) begin
                fetch_hold_q <= mem_rdata;
            end
            if (state_q == FETCH2) begin
                data_hold_q <= mem_rdata;
            end
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_stupidrv_memarb.sv
// Bench for stupidrv_memarb: step-level model plus a per-cycle compare.
// Includes a behavioural 1-cycle-latency word memory.
module tb_stupidrv_memarb;

    localparam int AW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   imem_addr, imem_data;
    logic          dmem_valid;
    logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]    dmem_wstrb;
    logic          stall, mem_en;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_wdata, mem_rdata, stall_cycles;

    stupidrv_memarb #(.MEM_ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .stall(stall),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    // Environment memory: read-before-write, data valid next cycle.
    logic [31:0] mem [1024];
    always @(posedge clock) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    // Step-level reference model.
    logic [31:0] gm [1024];
    logic [31:0] exp_imem, exp_dmem, exp_cnt;
    logic        exp_stall;
    logic [AW-1:0] exp_addr;
    logic        in_rst;
    logic        chk_en;
    int          vectors, miscompares;

    function automatic logic [AW-1:0] widx(input logic [31:0] a);
        return a[AW+1:2];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, exp_stall});
            chk("imem_data", imem_data, exp_imem);
            chk("dmem_rdata", dmem_rdata, exp_dmem);
            chk("stall_cycles", stall_cycles, exp_cnt);
            if (in_rst) begin
                chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
                chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
            end else begin
                chk("mem_en", {31'd0, mem_en}, 32'd1);
                chk("mem_addr", {22'd0, mem_addr}, {22'd0, exp_addr});
            end
        end
    end

    task automatic enter_reset();
        reset = 1'b0; in_rst = 1'b1; exp_stall = 1'b1;
        exp_imem = 0; exp_dmem = 0; exp_cnt = 0;
    endtask

    task automatic leave_reset();
        reset = 1'b1; in_rst = 1'b0;
    endtask

    // One core step; when cut is set, reset hits during the FETCH2 cycle.
    task automatic step(input logic [31:0] ia, input logic dv, input logic [31:0] da,
                        input logic [3:0] ws, input logic [31:0] wd, input bit cut = 0);
        imem_addr = ia; dmem_valid = dv; dmem_addr = da;
        dmem_wstrb = ws; dmem_wdata = wd;
        exp_stall = dv;
        exp_addr  = dv ? widx(da) : widx(ia);
        @(posedge clock); #1;
        if (dv) begin
            exp_cnt++;
            if (cut) begin
                gm[widx(da)] = merge(gm[widx(da)], wd, ws);
                enter_reset();
                return;
            end
            exp_stall = 1'b0;
            exp_addr  = widx(ia);
            @(posedge clock); #1;
            exp_dmem = gm[widx(da)];
            gm[widx(da)] = merge(gm[widx(da)], wd, ws);
        end
        exp_imem = gm[widx(ia)];
    endtask

    logic [31:0] c0;

    initial begin
        vectors = 0; miscompares = 0; chk_en = 1'b0;
        imem_addr = 0; dmem_valid = 0; dmem_addr = 0; dmem_wstrb = 0; dmem_wdata = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;
        mem[16] = 32'hDEADBEEF;
        mem[4]  = 32'hFFFFFFFF;
        for (int i = 0; i < 1024; i++) gm[i] = mem[i];
        exp_addr = 0;
        enter_reset();
        chk_en = 1'b1;
        repeat (3) @(posedge clock);
        #1 leave_reset();

        step(32'h0, 0, 0, 0, 0);
        chk("lit_first_fetch", imem_data, 32'h100);
        step(32'h4, 0, 0, 0, 0);
        chk("lit_fetch1", imem_data, 32'h101);
        step(32'h8, 0, 0, 0, 0);
        chk("lit_fetch2", imem_data, 32'h102);
        step(32'h1000_000C, 0, 0, 0, 0);
        chk("lit_wrap_hi", imem_data, 32'h103);
        step(32'h7, 0, 0, 0, 0);
        chk("lit_wrap_lo", imem_data, 32'h101);

        step(32'h8, 1, 32'h40, 4'b0000, 0);
        chk("lit_load_d", dmem_rdata, 32'hDEADBEEF);
        chk("lit_load_i", imem_data, 32'h102);
        chk("lit_load_cnt", stall_cycles, 32'd1);

        step(32'h10, 1, 32'h10, 4'b0011, 32'h1234ABCD);
        chk("lit_store_i", imem_data, 32'hFFFFABCD);
        chk("lit_store_d", dmem_rdata, 32'hFFFFFFFF);
        chk("lit_store_mem", mem[4], 32'hFFFFABCD);

        c0 = exp_cnt;
        step(32'h4, 1, 32'h40, 0, 0);
        step(32'h4, 1, 32'h0, 0, 0);
        chk("lit_b2b_d1", dmem_rdata, 32'h100);
        step(32'h4, 1, 32'h8, 0, 0);
        chk("lit_b2b_d2", dmem_rdata, 32'h102);
        chk("lit_b2b_cnt", stall_cycles - c0, 32'd3);

        step(32'h0, 1, 32'h14, 4'b1111, 32'hCAFEF00D, 1);
        chk("lit_cut_mem", mem[5], 32'hCAFEF00D);
        repeat (2) @(posedge clock);
        #1 leave_reset();
        step(32'h14, 0, 0, 0, 0);
        chk("lit_cut_fetch", imem_data, 32'hCAFEF00D);
        step(32'h0, 1, 32'h14, 0, 0);
        chk("lit_cut_load", dmem_rdata, 32'hCAFEF00D);
        chk("lit_cut_cnt", stall_cycles, 32'd1);
        step(32'h4, 0, 0, 0, 0);

        @(posedge clock); #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stupidrv_memarb.md
# stupidrv_memarb

Single-port memory arbiter between the stupidrv core's instruction-fetch and data ports and one shared synchronous word memory with 1-cycle read latency. Every core step issues a fetch; a step that also carries a data access is split into two memory cycles (data first, then fetch), with `stall` raised for the first. It also keeps a free-running count of stall cycles for performance measurement.

## Interface
- `MEM_ADDR_WIDTH`, 10, word-address width of the shared memory.
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `imem_addr` in 32: core fetch byte address.
- `imem_data` out 32: fetched instruction word.
- `dmem_valid` in 1: core data access request for this step.
- `dmem_addr` in 32: data byte address.
- `dmem_wstrb` in 4: byte write enables; 0 means read.
- `dmem_wdata` in 32: write data.
- `dmem_rdata` out 32: data read word.
- `stall` out 1: core must hold all outputs and not advance this cycle.
- `mem_en` out 1: memory access enable.
- `mem_addr` out MEM_ADDR_WIDTH: word address (byte address bits `[MEM_ADDR_WIDTH+1:2]`).
- `mem_wstrb` out 4: memory byte write enables.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid the cycle after `mem_en`.
- `stall_cycles` out 32: number of cycles with `stall` high since reset.

## Operation
- States: `IDLE`, `FETCH2`.
- `IDLE`, `dmem_valid`=0: issue fetch (`mem_en`=1, `mem_addr`=imem word, `mem_wstrb`=0), `stall`=0, stay `IDLE`.
- `IDLE`, `dmem_valid`=1: issue data access (dmem addr/wstrb/wdata), `stall`=1, go `FETCH2`.
- `FETCH2`: issue fetch from (held) `imem_addr`, `stall`=0, capture `mem_rdata` into data hold reg, go `IDLE`. `dmem_valid` is ignored in `FETCH2`.
- `last_op` reg (NONE/FETCH/DATA) records the previous cycle's memory op.
- `imem_data` = `mem_rdata` when `last_op`=FETCH; else fetch hold reg (last fetched word). Fetch hold reg loads `mem_rdata` whenever `last_op`=FETCH.
- `dmem_rdata` = data hold reg; it loads in `FETCH2` for every data access, including writes, where the loaded value is the pre-write word.
- Write followed by fetch of the same word: the fetch returns the newly written data, because the write is issued first.
- `stall_cycles` increments by 1 on each cycle with `stall`=1, wraps modulo 2^32.

## Timing
- While `reset` is low: `stall`=1, `mem_en`=0, `mem_wstrb`=0, state `IDLE`, `last_op`=NONE, hold regs 0, `imem_data`=0, `dmem_rdata`=0, `stall_cycles`=0.
- `stall`, `mem_*` are combinational from state and core inputs; the core samples its inputs at the clock edge.
- Fetch-only step: address in cycle N, `imem_data` valid in cycle N+1. One cycle per step, no stall.
- Data step: data op in N (`stall`=1), fetch in N+1. `imem_data` and `dmem_rdata` are both valid in N+2 and hold until overwritten.
- Back-to-back data steps: `stall` pattern 1,0,1,0; throughput 2 cycles/step.
- Reset asserted mid-step: return to `IDLE` immediately. A data write issued on an edge before reset took effect is kept; the pending fetch is dropped.
- Address bits above `MEM_ADDR_WIDTH+1` and bits `[1:0]` are ignored, so addresses wrap within the memory.

## Structure
- Package `stupidrv_pkg`: state enum `{IDLE, FETCH2}`, `last_op` enum `{OP_NONE, OP_FETCH, OP_DATA}`, constant `MEM_LATENCY = 1`.
- No sub-module. The stall counter is inline.

## Test plan
- Reset low for 3 cycles, then release: `stall`=1 and `mem_en`=0 during reset. The first cycle after release fetches `imem_addr`=0, and `imem_data` equals mem[0] the next cycle.
- Fetch-only stream 0x0,0x4,0x8 with mem[i]=0x100+i: `imem_data` is 0x100, 0x101, 0x102 on consecutive cycles; `stall` stays 0.
- Load at 0x40 (mem[16]=0xDEADBEEF) with `imem_addr`=0x8: `stall`=1 for one cycle; two cycles later `dmem_rdata`=0xDEADBEEF and `imem_data`=mem[2]; `stall_cycles`=1.
- Store `wstrb`=4'b0011, `wdata`=0x1234ABCD to 0x10, where mem[4]=0xFFFFFFFF and `imem_addr`=0x10: mem[4]=0xFFFFABCD, and `imem_data` returns 0xFFFFABCD.
- Three back-to-back loads: `stall` pattern 1,0,1,0,1,0; `stall_cycles`=3; each `dmem_rdata` is correct.
- Assert `reset` in the `FETCH2` cycle of a store: the store is retained in memory, state is `IDLE`, and outputs take their reset values; the next step after release completes normally.
